// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the BRAM arbiter: FSM states, the response
// pipeline entry and the default geometry of the shared memory.
package bram_arb_pkg;

   localparam int DEF_ADDR_W = 14;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 64;

   // Requester ids are carried in a fixed-width field wide enough for 4 requesters.
   localparam int ID_W = 2;

   typedef enum logic {
      CLEAR = 1'b0,
      SERVE = 1'b1
   } arb_state_e;

   // One entry of the response pipeline: the access issued last cycle.
   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
      logic            err;
   } rsp_entry_t;

endpackage

// File: rtl/bram_arbiter_rr.sv
// Combinational round-robin arbiter: grants the first requester found when
// scanning cyclically from the pointer position.
module rr_arbiter
   import bram_arb_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o
);

   // One extra bit so ptr + offset cannot overflow before the modulo fold.
   localparam int SUM_W = IDX_W + 1;

   logic [SUM_W-1:0] cand_sum;
   logic [IDX_W-1:0] cand;
   logic             found;

   // Scan offsets 0..N-1 from the pointer and keep the first active request.
   always_comb begin
      gnt_o    = '0;
      idx_o    = '0;
      found    = 1'b0;
      cand_sum = '0;
      cand     = '0;
      for (int i = 0; i < N; i++) begin
         cand_sum = {1'b0, ptr_i} + SUM_W'(i);
         if (cand_sum >= SUM_W'(N)) begin
            cand_sum = cand_sum - SUM_W'(N);
         end
         cand = cand_sum[IDX_W-1:0];
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port BRAM between NUM_REQ valid/ready requesters with
// round-robin arbitration, one access per cycle and a fixed 1-cycle response.
// Optionally zero-fills the memory after reset before serving anyone.
module bram_arbiter
   import bram_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int DEPTH          = DEF_DEPTH,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ-1:0]        req_we_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [DATA_W-1:0]         rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      busy_o,
   output logic                      bram_en_o,
   output logic                      bram_we_o,
   output logic [ADDR_W-1:0]         bram_addr_o,
   output logic [DATA_W-1:0]         bram_d_o,
   input  logic [DATA_W-1:0]         bram_q_i
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);
   localparam arb_state_e       RST_STATE = CLEAR_ON_RESET ? CLEAR : SERVE;

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   rsp_entry_t       rsp_q, rsp_d;

   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic               sel_we;
   logic               in_range;
   logic               accept;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req_i (req_valid_i),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   // Route the granted requester's fields; extra top bit keeps the range
   // compare correct even when DEPTH equals 2**ADDR_W.
   assign sel_addr  = req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
   assign sel_wdata = req_wdata_i[gnt_idx*DATA_W +: DATA_W];
   assign sel_we    = req_we_i[gnt_idx];
   assign in_range  = ({1'b0, sel_addr} < DEPTH_EXT);

   // Next-state, grant and BRAM drive. Ready is forced low while reset is
   // held so no requester sees an acceptance that the registers will drop.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      rsp_d       = '0;
      req_ready_o = '0;
      bram_en_o   = 1'b0;
      bram_we_o   = 1'b0;
      bram_addr_o = '0;
      bram_d_o    = '0;
      accept      = 1'b0;
      case (state_q)
         CLEAR: begin
            bram_en_o   = 1'b1;
            bram_we_o   = 1'b1;
            bram_addr_o = ADDR_W'(cnt_q);
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = SERVE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SERVE: begin
            accept      = rst_ni && (|gnt);
            bram_addr_o = sel_addr;
            bram_d_o    = sel_wdata;
            if (accept) begin
               req_ready_o = gnt;
               // Out-of-range requests are accepted but never touch the BRAM.
               bram_en_o   = in_range;
               bram_we_o   = in_range && sel_we;
               ptr_d       = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + IDX_W'(1);
               rsp_d.valid = 1'b1;
               rsp_d.id    = ID_W'(gnt_idx);
               rsp_d.err   = !in_range;
            end
         end
         default: begin
            state_d = RST_STATE;
         end
      endcase
   end

   // State, fill counter, round-robin pointer and the in-flight response entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
         ptr_q   <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         rsp_q   <= rsp_d;
      end
   end

   // Response decode: one-hot strobe, error flag, and BRAM data masked to
   // zero for out-of-range accesses where the BRAM output is stale.
   always_comb begin
      rsp_valid_o = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         rsp_valid_o[k] = rsp_q.valid && (rsp_q.id == ID_W'(k));
      end
      rsp_err_o   = rsp_q.valid && rsp_q.err;
      rsp_rdata_o = (rsp_q.valid && !rsp_q.err) ? bram_q_i : '0;
   end

   assign busy_o = (state_q == CLEAR);

`ifndef SYNTHESIS
   // A stalled requester must keep its request valid and unchanged.
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_hold_chk
      a_hold_stable : assert property (
         @(posedge clk_i) disable iff (!rst_ni)
         (req_valid_i[k] && !req_ready_o[k]) |=>
            (req_valid_i[k]
             && $stable(req_we_i[k])
             && $stable(req_addr_i[k*ADDR_W +: ADDR_W])
             && $stable(req_wdata_i[k*DATA_W +: DATA_W])));
   end
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: behavioural BRAM, table of per-cycle vectors,
// response scoreboard and hand-written reset/fill sequences.
module tb_bram_arbiter;

   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 14;
   localparam int DATA_W  = 32;
   localparam int DEPTH   = 64;

   logic                      clk_i;
   logic                      rst_ni;
   logic [NUM_REQ-1:0]        req_valid_i;
   logic [NUM_REQ-1:0]        req_ready_o;
   logic [NUM_REQ-1:0]        req_we_i;
   logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
   logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
   logic [NUM_REQ-1:0]        rsp_valid_o;
   logic [DATA_W-1:0]         rsp_rdata_o;
   logic                      rsp_err_o;
   logic                      busy_o;
   logic                      bram_en_o;
   logic                      bram_we_o;
   logic [ADDR_W-1:0]         bram_addr_o;
   logic [DATA_W-1:0]         bram_d_o;
   logic [DATA_W-1:0]         bram_q_i;

   bram_arbiter #(
      .NUM_REQ        (NUM_REQ),
      .ADDR_W         (ADDR_W),
      .DATA_W         (DATA_W),
      .DEPTH          (DEPTH),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_we_i    (req_we_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .busy_o      (busy_o),
      .bram_en_o   (bram_en_o),
      .bram_we_o   (bram_we_o),
      .bram_addr_o (bram_addr_o),
      .bram_d_o    (bram_d_o),
      .bram_q_i    (bram_q_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Behavioural single-port BRAM, read-before-write, 1-cycle read latency.
   logic [DATA_W-1:0] bram_mem [0:DEPTH-1];
   logic              scramble;
   always @(posedge clk_i) begin
      if (scramble) begin
         for (int i = 0; i < DEPTH; i++) bram_mem[i] <= 32'hBAD0_0000 | 32'(i);
      end else if (bram_en_o) begin
         bram_q_i <= bram_mem[bram_addr_o[5:0]];
         if (bram_we_o) bram_mem[bram_addr_o[5:0]] <= bram_d_o;
      end
   end

   typedef struct packed {
      logic [1:0]  v;
      logic [1:0]  we;
      logic [13:0] a0;
      logic [13:0] a1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [1:0]  exp_ready;
      logic        exp_en;
   } vec_t;

   typedef struct packed {
      logic [1:0]  vld;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [0:DEPTH-1];
   vec_t        tbl [15];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic check_rsp(input string name);
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check($sformatf("%s rsp", name), 64'({rsp_valid_o, rsp_err_o, rsp_rdata_o}), 64'(e));
      end else begin
         check($sformatf("%s no_rsp", name), 64'(rsp_valid_o), 64'(0));
      end
   endtask

   // Called at a falling edge: drive, check, record acceptance, advance.
   task automatic apply(input string name, input vec_t t);
      int          k;
      logic [13:0] a;
      logic [31:0] d;
      exp_t        e;
      req_valid_i = t.v;
      req_we_i    = t.we;
      req_addr_i  = {t.a1, t.a0};
      req_wdata_i = {t.d1, t.d0};
      #1;
      check_rsp(name);
      check($sformatf("%s ctl", name), 64'({req_ready_o, bram_en_o, busy_o}),
            64'({t.exp_ready, t.exp_en, 1'b0}));
      if (t.exp_ready != 2'b00) begin
         k = t.exp_ready[1] ? 1 : 0;
         a = (k == 1) ? t.a1 : t.a0;
         d = (k == 1) ? t.d1 : t.d0;
         if (t.exp_en) begin
            check($sformatf("%s bram", name),
                  64'({bram_we_o, bram_addr_o, t.we[k] ? bram_d_o : 32'h0}),
                  64'({t.we[k], a, t.we[k] ? d : 32'h0}));
         end
         e.vld = t.exp_ready;
         if (a < 14'd64) begin
            e.err   = 1'b0;
            e.rdata = ref_mem[a[5:0]];
            if (t.we[k]) ref_mem[a[5:0]] = d;
         end else begin
            e.err   = 1'b1;
            e.rdata = 32'h0;
         end
         sb.push_back(e);
      end
      @(negedge clk_i);
   endtask

   // Called at the falling edge where reset was released.
   task automatic fill_check(input string name);
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         check_rsp($sformatf("%s[%0d]", name, i));
         check($sformatf("%s[%0d] drive", name, i),
               64'({busy_o, bram_en_o, bram_we_o, bram_addr_o, bram_d_o, req_ready_o}),
               64'({1'b1, 1'b1, 1'b1, 14'(i), 32'h0, 2'b00}));
         @(negedge clk_i);
      end
   endtask

   vec_t p;

   initial begin
      //            v      we     a0      a1      d0            d1     rdy    en
      tbl[0]  = '{2'b01, 2'b00, 14'd5,  14'd0,  32'h0,        32'h0, 2'b01, 1'b1};
      tbl[1]  = '{2'b01, 2'b01, 14'd10, 14'd0,  32'hDEADBEEF, 32'h0, 2'b01, 1'b1};
      tbl[2]  = '{2'b01, 2'b00, 14'd10, 14'd0,  32'h0,        32'h0, 2'b01, 1'b1};
      tbl[3]  = '{2'b00, 2'b00, 14'd0,  14'd0,  32'h0,        32'h0, 2'b00, 1'b0};
      tbl[4]  = '{2'b10, 2'b00, 14'd0,  14'd64, 32'h0,        32'h0, 2'b10, 1'b0};
      tbl[5]  = '{2'b11, 2'b01, 14'd20, 14'd20, 32'h11110000, 32'h0, 2'b01, 1'b1};
      tbl[6]  = '{2'b11, 2'b01, 14'd21, 14'd20, 32'h22220000, 32'h0, 2'b10, 1'b1};
      tbl[7]  = '{2'b11, 2'b01, 14'd21, 14'd21, 32'h22220000, 32'h0, 2'b01, 1'b1};
      tbl[8]  = '{2'b11, 2'b00, 14'd20, 14'd21, 32'h0,        32'h0, 2'b10, 1'b1};
      tbl[9]  = '{2'b11, 2'b00, 14'd20, 14'd5,  32'h0,        32'h0, 2'b01, 1'b1};
      tbl[10] = '{2'b11, 2'b00, 14'd21, 14'd5,  32'h0,        32'h0, 2'b10, 1'b1};
      tbl[11] = '{2'b01, 2'b00, 14'd21, 14'd0,  32'h0,        32'h0, 2'b01, 1'b1};
      tbl[12] = '{2'b01, 2'b01, 14'd3,  14'd0,  32'h12345678, 32'h0, 2'b01, 1'b1};
      tbl[13] = '{2'b10, 2'b00, 14'd0,  14'd3,  32'h0,        32'h0, 2'b10, 1'b1};
      tbl[14] = '{2'b00, 2'b00, 14'd0,  14'd0,  32'h0,        32'h0, 2'b00, 1'b0};

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
      rst_ni      = 1'b1;
      scramble    = 1'b0;
      req_valid_i = '0;
      req_we_i    = '0;
      req_addr_i  = '0;
      req_wdata_i = '0;
      #1 rst_ni = 1'b0;

      // Fill memory with garbage under reset; req0 holds a read of addr 5.
      @(negedge clk_i);
      scramble    = 1'b1;
      req_valid_i = 2'b01;
      req_addr_i  = {14'd0, 14'd5};
      @(negedge clk_i);
      scramble = 1'b0;
      #1;
      check("reset", 64'({rsp_valid_o, rsp_err_o, rsp_rdata_o, req_ready_o, busy_o}),
            64'({2'b00, 1'b0, 32'h0, 2'b00, 1'b1}));
      @(negedge clk_i);
      rst_ni = 1'b1;
      fill_check("fill1");

      for (int i = 0; i < 15; i++) apply($sformatf("vec%0d", i), tbl[i]);

      // Reset while a read is in flight: its response must never appear.
      req_valid_i = 2'b01;
      req_we_i    = 2'b00;
      req_addr_i  = {14'd0, 14'd10};
      #1;
      check_rsp("midrst");
      check("midrst accept", 64'({req_ready_o, bram_en_o}), 64'({2'b01, 1'b1}));
      #1;
      rst_ni      = 1'b0;
      req_valid_i = 2'b00;
      sb.delete();
      @(posedge clk_i);
      #1;
      check("midrst drop", 64'({rsp_valid_o, busy_o, bram_addr_o}), 64'({2'b00, 1'b1, 14'd0}));
      @(negedge clk_i);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      fill_check("fill2");

      // Pointer restarts at 0 and the refill erased the earlier writes.
      p = '{2'b11, 2'b00, 14'd10, 14'd11, 32'h0, 32'h0, 2'b01, 1'b1};
      apply("post0", p);
      p = '{2'b10, 2'b00, 14'd0,  14'd11, 32'h0, 32'h0, 2'b10, 1'b1};
      apply("post1", p);
      p = '{2'b00, 2'b00, 14'd0,  14'd0,  32'h0, 32'h0, 2'b00, 1'b0};
      apply("post2", p);
      apply("post3", p);
      check("drain", 64'(sb.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares one single-port bram_64kib instance between NUM_REQ requesters, e.g. instruction fetch and load/store.
- Uses a valid/ready request handshake with round-robin arbitration and issues at most one BRAM access per cycle.
- Routes the 1-cycle-latency read data back to the requester that issued the access.
- After reset, optionally zero-fills the whole BRAM before serving any request.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 14, request and BRAM address width.
- DATA_W, 32, data width.
- DEPTH, 64, number of implemented BRAM words; addresses >= DEPTH are out of range.
- CLEAR_ON_RESET, 1, 1 = zero-fill the memory after reset; 0 = serve requests immediately.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester request accepted this cycle.
- req_we_i  in  NUM_REQ  per-requester write enable (1 = write, 0 = read).
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k occupies [k*ADDR_W +: ADDR_W].
- req_wdata_i  in  NUM_REQ*DATA_W  packed write data, packed the same way.
- rsp_valid_o  out  NUM_REQ  one-hot response strobe.
- rsp_rdata_o  out  DATA_W  shared read data; valid only while rsp_valid_o is nonzero.
- rsp_err_o  out  1  response refers to an out-of-range address.
- busy_o  out  1  high during zero-fill.
- bram_en_o  out  1  BRAM enable.
- bram_we_o  out  1  BRAM write enable.
- bram_addr_o  out  ADDR_W  BRAM address.
- bram_d_o  out  DATA_W  BRAM write data.
- bram_q_i  in  DATA_W  BRAM read data, valid 1 cycle after enable.

Behaviour:
- Reset values:
  - State = CLEAR if CLEAR_ON_RESET, else SERVE.
  - Fill counter = 0; round-robin pointer = 0.
  - Response pipeline register cleared.
  - rsp_valid_o = 0, rsp_err_o = 0, rsp_rdata_o = 0, req_ready_o = 0.
  - busy_o = CLEAR_ON_RESET.
- FSM states: CLEAR, SERVE.
- CLEAR:
  - Each cycle drive bram_en_o=1, bram_we_o=1, bram_addr_o=counter, bram_d_o=0.
  - req_ready_o = 0 for all requesters.
  - After the write at counter = DEPTH-1, go to SERVE; busy_o falls in the same edge.
  - Takes exactly DEPTH cycles.
- SERVE, grant:
  - Grant goes to the lowest index k, counted cyclically starting at the pointer, with req_valid_i[k]=1.
  - req_ready_o is the one-hot grant, combinational from req_valid_i.
  - With no valid request, ready = 0 and bram_en_o = 0.
- SERVE, accepted request (valid & ready):
  - In-range address: bram_en_o=1, bram_we_o=req_we_i[k], bram_addr_o/bram_d_o from requester k, all combinational in the same cycle.
  - Out-of-range address: bram_en_o=0; the request is still accepted.
  - Pointer <= (k+1) mod NUM_REQ on each acceptance; unchanged when idle.
- Response, cycle after acceptance:
  - rsp_valid_o[k] = 1 for exactly 1 cycle, for reads and writes alike.
  - rsp_rdata_o = bram_q_i for in-range accesses; this is the old word for writes (read-before-write).
  - For out-of-range accesses: rsp_rdata_o = 0 and rsp_err_o = 1.
  - Responses have no backpressure.
- Throughput and latency:
  - Back-to-back acceptances every cycle are allowed, giving 1 access/cycle.
  - Latency from acceptance to response is fixed at 1 cycle.
- Requester rules: while valid is high and ready is low, the requester holds we, addr and wdata stable and does not drop valid. The controller asserts this in simulation only.
- Simultaneous events:
  - All requesters valid: strict rotation, so each requester waits at most NUM_REQ-1 cycles.
  - Same-address write then read in consecutive cycles: the read returns the new data.
- Reset mid-operation: everything returns to reset values immediately, the in-flight response is dropped, and zero-fill restarts.
- Combinational path: req_valid_i -> req_ready_o and bram_* is permitted, since the BRAM registers its inputs.

Decomposition:
- Package bram_arb_pkg holds:
  - ADDR_W, DATA_W and DEPTH defaults.
  - typedef enum logic {CLEAR, SERVE} arb_state_e.
  - typedef struct for the response pipeline entry: valid, id, err.
- One natural sub-module, rr_arbiter (parameter N):
  - Inputs: request vector and pointer.
  - Output: one-hot grant and grant index.
  - Purely combinational.

Test Plan:
- Reset with CLEAR_ON_RESET=1: busy_o high for 64 cycles, bram_we_o=1 with addr 0..63 and d=0, no ready during fill. Then reading addr 5 returns 0x00000000.
- Single requester: req0 writes 0xDEADBEEF to addr 10; the next-cycle response returns the old word (0). A following req0 read of addr 10 gives rsp_valid_o=01 one cycle later with rdata 0xDEADBEEF.
- Contention with both requesters valid continuously for 6 cycles, pointer=0: grants follow 0,1,0,1,0,1 and responses alternate 01,10 each delayed by 1 cycle.
- Out of range: req1 reads addr 64 -> accepted, bram_en_o=0, next cycle rsp_valid_o=10, rsp_err_o=1, rdata=0.
- Back-to-back: req0 writes addr 3=0x12345678, then the next cycle req1 reads addr 3 -> req1 gets 0x12345678.
- Reset mid-operation: deassert rst_ni the cycle after a read is accepted -> no rsp_valid_o pulse, busy_o=1, and the fill restarts at addr 0.
